aging_arbiter: RTL

- Shares one resource between REQUESTERS clients.
- Each requester has an internal saturating wait-age counter. The oldest waiter wins; ties are resolved round-robin.
- Grants are registered and held until the owner drops its request. Handover to the next winner happens with no idle cycle.
- Sits in front of any shared single-owner resource (bus port, table write port, counter update port).

---
 rtl/aging_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/aging_arbiter.sv
// rtl/aging_arbiter.sv - single-owner arbiter: oldest waiter wins, round-robin tie-break, held grants
// Optional AGING_ARBITER_STARVATION_FLAG_EN adds a registered per-requester starving output.
module aging_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int AGE_RANGE  = 4,
  localparam int AGE_WIDTH   = $clog2(AGE_RANGE),
  localparam int INDEX_WIDTH = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [REQUESTERS-1:0]  requests,
  output logic [REQUESTERS-1:0]  grant,
  output logic                   grant_valid,
  output logic [INDEX_WIDTH-1:0] grant_index
`ifdef AGING_ARBITER_STARVATION_FLAG_EN
  ,
  output logic [REQUESTERS-1:0]  starving
`endif
);

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(AGE_RANGE - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_n;
  logic [REQUESTERS-1:0]  grant_n;
  logic [INDEX_WIDTH-1:0] index_n;
  logic [INDEX_WIDTH-1:0] rr_ptr, rr_n;
  logic [AGE_WIDTH-1:0]   age   [REQUESTERS];
  logic [AGE_WIDTH-1:0]   age_n [REQUESTERS];

  logic [REQUESTERS-1:0]  eligible;
  logic                   owner_hold;
  logic                   arbitrate;
  logic                   win_found;
  logic [INDEX_WIDTH-1:0] win_idx;
  logic [AGE_WIDTH-1:0]   best_age;
  int                     scan;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_index <= '0;
      rr_ptr      <= '0;
      for (int i = 0; i < REQUESTERS; i++) age[i] <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_valid <= |grant_n;
      grant_index <= index_n;
      rr_ptr      <= rr_n;
      for (int i = 0; i < REQUESTERS; i++) age[i] <= age_n[i];
    end
  end

  always_comb begin
    // The current owner is masked out, so a releasing owner can never re-win.
    eligible   = requests & ~grant;
    owner_hold = |(requests & grant);

    // Cyclic scan from rr_ptr; strict '>' keeps the first tied index found.
    win_found = 1'b0;
    win_idx   = '0;
    best_age  = '0;
    scan      = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= REQUESTERS) scan = scan - REQUESTERS;
      if (eligible[scan] && (!win_found || age[scan] > best_age)) begin
        win_found = 1'b1;
        win_idx   = INDEX_WIDTH'(scan);
        best_age  = age[scan];
      end
    end

    arbitrate = 1'b0;
    state_n   = state;
    grant_n   = grant;
    index_n   = grant_index;
    rr_n      = rr_ptr;

    case (state)
      IDLE: begin
        if (win_found) begin
          arbitrate = 1'b1;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        if (!owner_hold) begin
          if (win_found) begin
            arbitrate = 1'b1;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase

    if (arbitrate) begin
      grant_n          = '0;
      grant_n[win_idx] = 1'b1;
      index_n          = win_idx;
      rr_n             = (int'(win_idx) == REQUESTERS - 1) ? '0 : win_idx + 1'b1;
    end

    for (int i = 0; i < REQUESTERS; i++) begin
      if (!requests[i] || grant[i] || (arbitrate && win_idx == INDEX_WIDTH'(i)))
        age_n[i] = '0;
      else if (age[i] != AGE_MAX)
        age_n[i] = age[i] + 1'b1;
      else
        age_n[i] = age[i];
    end
  end

`ifdef AGING_ARBITER_STARVATION_FLAG_EN
  // A saturated next age already implies "requesting and not granted".
  always_ff @(posedge clock) begin
    if (!resetn) begin
      starving <= '0;
    end else begin
      for (int i = 0; i < REQUESTERS; i++) starving[i] <= (age_n[i] == AGE_MAX);
    end
  end
`endif

endmodule
